// File: rtl/battle_director_if.sv
// Purpose : bundles every non-clock/reset signal of battle_director into one bus.
// Latency : none; this file holds wires only.
// Backpressure: none; keycode is level-valued and end_battle is a one-cycle pulse.
// Signals:
//   keycode    [7:0]      current USB keycode (8'h00 = no key)
//   end_battle            one-cycle completion pulse from the battle engine
//   result                battle outcome while end_battle=1 (1=win)
//   is_battle             battle request/hold (registered)
//   team       [2:0][2:0] selected species ids, slot 0 leads (registered)
//   cursor     [2:0]      highlighted species id
//   sel_count  [1:0]      filled slots (0..3)
//   screen     [2:0]      0=Title 1=Select 2=Confirm 3=Battle 4=Win 5=Lose
//   wins       [7:0]      total wins, saturating
//   streak     [7:0]      consecutive wins, saturating
interface battle_director_if;
    logic [7:0]      keycode;
    logic            end_battle;
    logic            result;
    logic            is_battle;
    logic [2:0][2:0] team;
    logic [2:0]      cursor;
    logic [1:0]      sel_count;
    logic [2:0]      screen;
    logic [7:0]      wins;
    logic [7:0]      streak;

    // Environment side: keyboard and battle engine.
    modport master (
        output keycode, end_battle, result,
        input  is_battle, team, cursor, sel_count, screen, wins, streak
    );

    // Director side.
    modport slave (
        input  keycode, end_battle, result,
        output is_battle, team, cursor, sel_count, screen, wins, streak
    );
endinterface

// File: rtl/battle_director.sv
// Purpose : game-level controller: title, 3-pick team menu, battle handshake, win/lose stats.
// Latency : is_battle rises 2 edges after the Confirm ENTER event, falls 1 edge after end_battle.
// Backpressure: none; keys act only on new-press events, end_battle only counts in InBattle.
// Ports:
//   Clk    system clock
//   Reset  synchronous active-low reset
//   bus    battle_director_if.slave (keycode/end_battle/result in, menu and stats out)
module battle_director #(
    parameter int NUM_MON = 6
) (
    input  logic                Clk,
    input  logic                Reset,
    battle_director_if.slave    bus
);

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [2:0] EMPTY     = 3'b111;
    localparam logic [2:0] LAST_ID   = 3'(NUM_MON - 1);

    typedef enum logic [2:0] {
        ST_TITLE    = 3'd0,
        ST_SELECT   = 3'd1,
        ST_CONFIRM  = 3'd2,
        ST_START    = 3'd3,
        ST_INBATTLE = 3'd4,
        ST_WIN      = 3'd5,
        ST_LOSE     = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      prev_key_q;
    logic            is_battle_q, is_battle_d;
    logic [2:0][2:0] team_q, team_d;
    logic [2:0]      cursor_q, cursor_d;
    logic [1:0]      sel_count_q, sel_count_d;
    logic [7:0]      wins_q, wins_d;
    logic [7:0]      streak_q, streak_d;

    logic key_ev;
    logic ev_a, ev_d, ev_s, ev_enter;
    logic dup;

    // A held key produces one event only: it must differ from last cycle's code.
    assign key_ev   = (bus.keycode != 8'h00) && (bus.keycode != prev_key_q);
    assign ev_a     = key_ev && (bus.keycode == KEY_A);
    assign ev_d     = key_ev && (bus.keycode == KEY_D);
    assign ev_s     = key_ev && (bus.keycode == KEY_S);
    assign ev_enter = key_ev && (bus.keycode == KEY_ENTER);

    // Species may appear only once in the team; only filled slots are compared.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((2'(i) < sel_count_q) && (team_q[i] == cursor_q)) begin
                dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        is_battle_d = is_battle_q;
        team_d      = team_q;
        cursor_d    = cursor_q;
        sel_count_d = sel_count_q;
        wins_d      = wins_q;
        streak_d    = streak_q;

        case (state_q)
            ST_TITLE: begin
                if (ev_enter) begin
                    state_d     = ST_SELECT;
                    cursor_d    = 3'd0;
                    sel_count_d = 2'd0;
                    team_d      = {3{EMPTY}};
                end
            end
            ST_SELECT: begin
                if (ev_d) begin
                    cursor_d = (cursor_q == LAST_ID) ? 3'd0 : cursor_q + 3'd1;
                end else if (ev_a) begin
                    cursor_d = (cursor_q == 3'd0) ? LAST_ID : cursor_q - 3'd1;
                end else if (ev_enter) begin
                    if (!dup) begin
                        team_d[sel_count_q] = cursor_q;
                        sel_count_d         = sel_count_q + 2'd1;
                        if (sel_count_q == 2'd2) begin
                            state_d = ST_CONFIRM;
                        end
                    end
                end else if (ev_s) begin
                    if (sel_count_q != 2'd0) begin
                        team_d[sel_count_q - 2'd1] = EMPTY;
                        sel_count_d                = sel_count_q - 2'd1;
                    end else begin
                        state_d = ST_TITLE;
                    end
                end
            end
            ST_CONFIRM: begin
                if (ev_enter) begin
                    state_d = ST_START;
                end else if (ev_s) begin
                    team_d[2]   = EMPTY;
                    sel_count_d = 2'd2;
                    state_d     = ST_SELECT;
                end
            end
            ST_START: begin
                // Team is frozen from here until is_battle drops.
                is_battle_d = 1'b1;
                state_d     = ST_INBATTLE;
            end
            ST_INBATTLE: begin
                // Keys belong to the engine now; only end_battle matters.
                if (bus.end_battle) begin
                    is_battle_d = 1'b0;
                    if (bus.result) begin
                        state_d  = ST_WIN;
                        wins_d   = (wins_q == 8'hFF) ? wins_q : wins_q + 8'd1;
                        streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
                    end else begin
                        state_d  = ST_LOSE;
                        streak_d = 8'd0;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (ev_enter) begin
                    state_d = ST_TITLE;
                end
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_TITLE;
            prev_key_q  <= 8'h00;
            is_battle_q <= 1'b0;
            team_q      <= {3{EMPTY}};
            cursor_q    <= 3'd0;
            sel_count_q <= 2'd0;
            wins_q      <= 8'd0;
            streak_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            prev_key_q  <= bus.keycode;
            is_battle_q <= is_battle_d;
            team_q      <= team_d;
            cursor_q    <= cursor_d;
            sel_count_q <= sel_count_d;
            wins_q      <= wins_d;
            streak_q    <= streak_d;
        end
    end

    // Start and InBattle both show the battle screen.
    always_comb begin
        case (state_q)
            ST_TITLE:    bus.screen = 3'd0;
            ST_SELECT:   bus.screen = 3'd1;
            ST_CONFIRM:  bus.screen = 3'd2;
            ST_START:    bus.screen = 3'd3;
            ST_INBATTLE: bus.screen = 3'd3;
            ST_WIN:      bus.screen = 3'd4;
            ST_LOSE:     bus.screen = 3'd5;
            default:     bus.screen = 3'd0;
        endcase
    end

    assign bus.is_battle = is_battle_q;
    assign bus.team      = team_q;
    assign bus.cursor    = cursor_q;
    assign bus.sel_count = sel_count_q;
    assign bus.wins      = wins_q;
    assign bus.streak    = streak_q;

endmodule

// File: doc/battle_director.md
Name: battle_director

Overview:
- Game-level controller that drives the battle engine from the other side of its start/finish handshake.
- Runs a title screen and a three-pick team selection menu from keyboard keycodes.
- Raises is_battle and holds the selected team stable for the whole battle.
- Consumes the engine's end_battle/result pulse, then shows a win or lose screen and tracks win statistics before returning to the title.

Parameters:
NUM_MON, 6, number of selectable species; ids 0..NUM_MON-1; NUM_MON ≤ 7; id 7 is reserved as the empty-slot marker.

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-low reset (Reset=0 resets on posedge Clk)
keycode  input  8  current USB keycode, level-valued; 8'h00 = no key
end_battle  input  1  one-cycle pulse from battle engine on battle completion
result  input  1  battle outcome, valid only while end_battle=1 (1=win, 0=lose)
is_battle  output  1  request/hold battle; registered
team  output  [2:0][2:0]  selected species ids, slot 0 leads; registered
cursor  output  3  species id currently highlighted in the menu
sel_count  output  2  number of slots filled (0..3)
screen  output  3  0=Title, 1=Select, 2=Confirm, 3=Battle, 4=Win, 5=Lose
wins  output  8  total battles won, saturating
streak  output  8  consecutive wins, saturating

Behaviour:
- Reset (Reset=0):
  - state=Title, is_battle=0, team all 3'b111, cursor=0, sel_count=0, wins=0, streak=0.
  - Previous-key register=8'h00.
  - Reset wins over every other event, including an end_battle arriving on the same cycle.
- Key events:
  - prev_key <= keycode every cycle.
  - key_ev = (keycode != 8'h00) && (keycode != prev_key).
  - Exactly one event per press, regardless of hold length; only events act.
  - Keycodes: W=8'h1A, A=8'h04, S=8'h16, D=8'h07, ENTER=8'h28.
- State Title:
  - ENTER ev -> Select; cursor=0, sel_count=0, team all 3'b111.
- State Select:
  - D ev: cursor+1, wraps NUM_MON-1 -> 0.
  - A ev: cursor-1, wraps 0 -> NUM_MON-1.
  - ENTER ev:
    - If cursor equals any filled slot, rejected; no change.
    - Otherwise team[sel_count] <= cursor and sel_count+1.
    - If this fills slot 2 (sel_count becomes 3) -> Confirm on the same edge.
  - S ev with sel_count > 0: team[sel_count-1] <= 3'b111, sel_count-1.
  - S ev with sel_count = 0 -> Title.
  - W ignored.
- State Confirm:
  - ENTER ev -> Start.
  - S ev: clears slot 2, sel_count=2 -> Select.
- State Start (1 cycle):
  - is_battle <= 1 on entry -> InBattle.
  - team frozen from here until is_battle falls.
- State InBattle:
  - is_battle held 1. Key events are ignored here because the engine consumes keys.
  - On end_battle=1, sample result. On the same edge:
    - is_battle <= 0.
    - result=1 -> Win; result=0 -> Lose.
  - is_battle must be low the cycle after end_battle so the engine's idle state does not restart.
  - end_battle outside InBattle is ignored.
- State Win:
  - On entry: wins+1 and streak+1, each saturating at 255.
  - ENTER ev -> Title.
- State Lose:
  - On entry: streak <= 0.
  - ENTER ev -> Title.
- Key held across a state change does not fire again in the new state, because it is not a new event.
- screen is a combinational decode of state; Start and InBattle both report 3.
- Latency:
  - is_battle rises 2 edges after the Confirm ENTER event (Confirm->Start, Start sets is_battle).
  - Falls 1 edge after end_battle.

Test Plan:
1. Reset=0 for 2 cycles mid-InBattle -> is_battle=0, screen=0, team=all 7, wins=0 next cycle.
2. Title, ENTER held 10 cycles -> exactly one transition to Select; cursor=0; A ev -> cursor=5 (NUM_MON=6); D ev -> 0.
3. Select: ENTER@0, D, ENTER@1, A, ENTER@0 (dup) -> sel_count=2, team={7,1,0}. Then D, D, ENTER -> team={2,1,0}, screen=2.
4. Confirm: S -> sel_count=2, slot2=7, screen=1. ENTER@2 -> Confirm; ENTER -> is_battle=1 two edges later; team unchanged while keycodes toggle.
5. InBattle: end_battle=1, result=1 for one cycle -> is_battle=0 next cycle, screen=4, wins=1, streak=1. Repeat with result=0 -> screen=5, streak=0, wins stays 1.
6. Preload wins=255 via 255 wins (or force) -> next win keeps wins=255. end_battle pulse while in Select -> no state change.
